// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache responder: FSM state
// encoding, default geometry and helpers that derive address-field widths.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_REFILL  = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    localparam int DEFAULT_LINES          = 16;
    localparam int DEFAULT_WORDS_PER_LINE = 4;

    // Width of the word-offset field inside a line.
    function automatic int offset_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Width of the line-index field.
    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    // Tag is whatever remains of the 30-bit word address.
    function automatic int tag_width(input int lines, input int words_per_line);
        return 30 - index_width(lines) - offset_width(words_per_line);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Direct-mapped line storage: valid bits, tag array and data array.
// One write port (a data word, optionally together with tag+valid),
// combinational read by index/offset, and a single-cycle clear of all
// valid bits. Data and tag arrays carry no reset.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINES          = DEFAULT_LINES,
    parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE,
    localparam int IW = index_width(LINES),
    localparam int OW = offset_width(WORDS_PER_LINE),
    localparam int TW = tag_width(LINES, WORDS_PER_LINE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          wr_word_en_i,
    input  logic          wr_tag_en_i,
    input  logic          wr_valid_i,
    input  logic [IW-1:0] wr_index_i,
    input  logic [OW-1:0] wr_offset_i,
    input  logic [31:0]   wr_data_i,
    input  logic [TW-1:0] wr_tag_i,
    input  logic [IW-1:0] rd_index_i,
    input  logic [OW-1:0] rd_offset_i,
    output logic          rd_valid_o,
    output logic [TW-1:0] rd_tag_o,
    output logic [31:0]   rd_data_o
);

    logic [31:0]   data_mem [LINES*WORDS_PER_LINE];
    logic [TW-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid_vec;

    // Data word write during refill.
    always_ff @(posedge clk) begin
        if (wr_word_en_i) begin
            data_mem[{wr_index_i, wr_offset_i}] <= wr_data_i;
        end
    end

    // Tag write when a line completes.
    always_ff @(posedge clk) begin
        if (wr_tag_en_i) begin
            tag_mem[wr_index_i] <= wr_tag_i;
        end
    end

    // One valid flop per line; flush clears every line in the same cycle
    // and overrides a simultaneous tag write.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            logic valid_bit_q;

            // Valid bit: cleared by reset/flush, loaded on tag write.
            always_ff @(posedge clk) begin
                if (!rst || flush_i) begin
                    valid_bit_q <= 1'b0;
                end else if (wr_tag_en_i && (wr_index_i == IW'(gi))) begin
                    valid_bit_q <= wr_valid_i;
                end
            end

            assign valid_vec[gi] = valid_bit_q;
        end
    endgenerate

    assign rd_valid_o = valid_vec[rd_index_i];
    assign rd_tag_o   = tag_mem[rd_index_i];
    assign rd_data_o  = data_mem[{rd_index_i, rd_offset_i}];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache front end. Accepts one CPU fetch at a
// time, answers hits one cycle after acceptance and refills missing lines
// word by word from backing memory.
// Optional feature: define ICACHE_STATS_EN to enable hit/miss counters;
// without it hit_cnt and miss_cnt are constant zero.
module icache_responder
    import icache_pkg::*;
#(
    parameter int LINES          = DEFAULT_LINES,
    parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int OW = offset_width(WORDS_PER_LINE);
    localparam int IW = index_width(LINES);
    localparam int TW = tag_width(LINES, WORDS_PER_LINE);

    state_e        state_q;
    logic [31:0]   addr_q;
    logic [OW-1:0] cnt_q;
    logic          hit_q;
    logic          flushed_q;
    logic          cpu_ready_q;
    logic [31:0]   cpu_rdata_q;
    logic          mem_req_q;
    logic [31:0]   mem_addr_q;

    // The store is looked up with the incoming address while idle so that
    // the hit decision is ready to register at acceptance; otherwise the
    // captured request address is used.
    logic [31:0]   rd_addr;
    logic          rd_valid;
    logic [TW-1:0] rd_tag;
    logic [31:0]   rd_data;
    logic          hit_d;
    logic          last_word;
    logic [OW-1:0] cnt_inc;
    logic          wr_word_en;
    logic          wr_tag_en;
    logic          wr_valid_d;

    assign rd_addr   = (state_q == ST_IDLE) ? cpu_addr : addr_q;
    assign hit_d     = rd_valid && (rd_tag == rd_addr[31:IW+OW+2]) && !flush;
    assign last_word = (cnt_q == {OW{1'b1}});
    assign cnt_inc   = cnt_q + 1'b1;

    // A flush seen anywhere in the refill leaves the line invalid.
    assign wr_word_en = (state_q == ST_REFILL) && mem_ack;
    assign wr_tag_en  = wr_word_en && last_word;
    assign wr_valid_d = !(flushed_q || flush);

    icache_line_store #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_store (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .wr_word_en_i (wr_word_en),
        .wr_tag_en_i  (wr_tag_en),
        .wr_valid_i   (wr_valid_d),
        .wr_index_i   (addr_q[IW+OW+1:OW+2]),
        .wr_offset_i  (cnt_q),
        .wr_data_i    (mem_rdata),
        .wr_tag_i     (addr_q[31:IW+OW+2]),
        .rd_index_i   (rd_addr[IW+OW+1:OW+2]),
        .rd_offset_i  (rd_addr[OW+1:2]),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_data_o    (rd_data)
    );

    // Main control FSM with registered CPU and memory outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            flushed_q   <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        hit_q   <= hit_d;
                        state_q <= ST_LOOKUP;
                        if (hit_d) begin
                            cpu_ready_q <= 1'b1;
                            cpu_rdata_q <= rd_data;
                        end
                    end
                end
                ST_LOOKUP: begin
                    if (hit_q) begin
                        cpu_ready_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q      <= '0;
                        flushed_q  <= 1'b0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {addr_q[31:OW+2], {OW{1'b0}}, 2'b00};
                        state_q    <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (flush) begin
                        flushed_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        cnt_q <= cnt_inc;
                        if (last_word) begin
                            mem_req_q   <= 1'b0;
                            cpu_ready_q <= 1'b1;
                            // The requested word may be arriving right now.
                            cpu_rdata_q <= (cnt_q == addr_q[OW+1:2]) ? mem_rdata : rd_data;
                            state_q     <= ST_RESPOND;
                        end else begin
                            mem_addr_q <= {addr_q[31:OW+2], cnt_inc, 2'b00};
                        end
                    end
                end
                ST_RESPOND: begin
                    cpu_ready_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Count each lookup outcome; counters wrap naturally and ignore flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (hit_q) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

    // Byte-offset bits are never used.
    logic unused_bits;
    assign unused_bits = ^{rd_addr[1:0], addr_q[1:0]};

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: stimulus pushes expected CPU data
// and expected memory addresses into queues; a CPU monitor and a memory
// responder pop and compare whenever the DUT presents a transaction.
module tb_icache_responder;

`ifdef ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    logic        flush_stim = 1'b0;
    logic        flush_resp = 1'b0;
    logic        resp_ack = 1'b0;
    logic [31:0] resp_rdata = '0;
    logic        stray_ack = 1'b0;

    assign flush     = flush_stim | flush_resp;
    assign mem_ack   = resp_ack | stray_ack;
    assign mem_rdata = stray_ack ? 32'hDEAD_BEEF : resp_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    int ack_limit = 1000;
    int flush_on_ack = 0;
    int acks_given = 0;

    logic [31:0] exp_data_q [$];
    logic [31:0] exp_mem_q  [$];

    icache_responder dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end else begin
            $display("ok   %s: %08h", nm, act);
        end
    endfunction

    // Backing-memory contents: line 0x40 holds 0x11..0x44, others addr+0x1000_0000.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a >= 32'h40 && a <= 32'h4C) return 32'h11 * (((a - 32'h40) >> 2) + 1);
        return a + 32'h1000_0000;
    endfunction

    // Memory responder: acks every requested word, checks its address.
    always @(negedge clk) begin
        resp_ack   = 1'b0;
        flush_resp = 1'b0;
        if (!mem_req) begin
            acks_given = 0;
        end else if (acks_given < ack_limit) begin
            if (exp_mem_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mem_unexpected_req: got addr %08h required no request", mem_addr);
            end else begin
                check("mem_addr", mem_addr, exp_mem_q.pop_front());
            end
            resp_ack   = 1'b1;
            resp_rdata = mem_data(mem_addr);
            acks_given++;
            if (acks_given == flush_on_ack) flush_resp = 1'b1;
        end
    end

    // CPU monitor: every ready pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (cpu_ready) begin
            if (exp_data_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cpu_unexpected_ready: got rdata %08h required no ready", cpu_rdata);
            end else begin
                check("cpu_rdata", cpu_rdata, exp_data_q.pop_front());
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input bit miss, input bit flush_req);
        int cyc;
        bit got;
        exp_data_q.push_back(exp);
        if (miss) begin
            for (int i = 0; i < 4; i++) exp_mem_q.push_back({a[31:4], 4'h0} + 32'(4 * i));
        end
        @(negedge clk);
        cpu_req    = 1'b1;
        cpu_addr   = a;
        flush_stim = flush_req;
        cyc = 0;
        got = 1'b0;
        while (cyc < 100 && !got) begin
            @(negedge clk);
            flush_stim = 1'b0;
            cyc++;
            if (cpu_ready) got = 1'b1;
        end
        cpu_req = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fetch_timeout: addr %08h got no ready required ready", a);
        end else begin
            check("latency", 32'(cyc), miss ? 32'd6 : 32'd1);
        end
        if (miss) exp_misses++;
        else exp_hits++;
        @(negedge clk);
        check("hit_cnt", hit_cnt, STATS ? 32'(exp_hits) : 32'd0);
        check("miss_cnt", miss_cnt, STATS ? 32'(exp_misses) : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        rst = 1'b1;

        // Cold miss, then hit in the same line.
        fetch(32'h40, 32'h11, 1'b1, 1'b0);
        fetch(32'h48, 32'h33, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rdata_hold", cpu_rdata, 32'h33);

        // Stray ack while idle must not disturb anything.
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        fetch(32'h48, 32'h33, 1'b0, 1'b0);

        // Conflicting tag replaces the line; original then misses again.
        fetch(32'h140, 32'h1000_0140, 1'b1, 1'b0);
        fetch(32'h40, 32'h11, 1'b1, 1'b0);

        // Flush together with the request: lookup misses.
        fetch(32'h44, 32'h22, 1'b1, 1'b1);
        fetch(32'h44, 32'h22, 1'b0, 1'b0);

        // Flush during the third refill word: data returned, line stays invalid.
        flush_on_ack = 3;
        fetch(32'h84, 32'h1000_0084, 1'b1, 1'b0);
        flush_on_ack = 0;
        fetch(32'h84, 32'h1000_0084, 1'b1, 1'b0);

        // Build a hit on 0x4C, then abort a refill of the same index by reset.
        fetch(32'h4C, 32'h44, 1'b1, 1'b0);
        fetch(32'h4C, 32'h44, 1'b0, 1'b0);
        ack_limit = 2;
        exp_mem_q.push_back(32'h240);
        exp_mem_q.push_back(32'h244);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 32'h240;
        k = 0;
        while (k < 50 && !(mem_ack && acks_given == 2)) begin
            @(posedge clk);
            k++;
        end
        if (k >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL reset_wait: got %0d acks required 2", acks_given);
        end
        @(negedge clk);
        rst     = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        check("rst_abort_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_abort_hit_cnt", hit_cnt, 32'd0);
        rst = 1'b1;
        ack_limit = 1000;
        exp_hits = 0;
        exp_misses = 0;
        fetch(32'h4C, 32'h44, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("data_queue_empty", 32'(exp_data_q.size()), 32'd0);
        check("mem_queue_empty", 32'(exp_mem_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
